// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a power-of-two FIFO drained by a frame serializer.
// Frame layout: start bit, then data bits LSB first, an optional parity bit, then 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int clk_freq  = 12000000,
    parameter int baud      = 115200,
    parameter int data_bits = 8,
    parameter int parity    = 0,
    parameter int stop_bits = 1,
    parameter int depth     = 16,
    localparam int AW       = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 put,
    input  logic [data_bits-1:0] data,
    input  logic                 clr_overflow,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 empty,
    output logic                 full,
    output logic [AW:0]          count,
    output logic                 overflow,
    output logic [2:0]           fsm_state
);

    localparam int DIV = clk_freq / baud;
    localparam int BW  = $clog2(DIV);

    localparam logic [BW-1:0] DIV_LAST  = BW'(DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(data_bits - 1);
    localparam logic [2:0]    STOP_LAST = 3'(stop_bits - 1);
    localparam logic [AW:0]   DEPTH_V   = (AW+1)'(depth);
    localparam logic          PAR_ODD   = (parity == 1);
    localparam logic          HAS_PAR   = (parity != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [data_bits-1:0] mem_q [depth];
    logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 overflow_q, overflow_d;
    logic [2:0]           state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [data_bits-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic                 wr_en, pop, tick;
    logic [data_bits-1:0] head;

    assign count     = wptr_q - rptr_q;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_V);
    assign overflow  = overflow_q;
    assign TX        = tx_q;
    assign tx_busy   = (state_q != S_IDLE);
    assign fsm_state = state_q;

    // Full is judged on registered state only, so a same-cycle pop never rescues a put.
    assign wr_en = put && !full;
    assign head  = mem_q[rptr_q[AW-1:0]];
    assign tick  = (baud_q == DIV_LAST);

    always_comb begin
        wptr_d     = wptr_q;
        overflow_d = overflow_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (put && full) overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = tick ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) pop = 1'b1;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                        tx_d    = HAS_PAR ? par_q : 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        if (!empty) pop = 1'b1;
                        else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // A pop always begins a new frame, from IDLE or straight out of the last stop bit.
        if (pop) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = head;
            par_d   = (^head) ^ PAR_ODD;
            tx_d    = 1'b0;
        end
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default 8N1 instance plus two 7-bit, 2-stop instances (even and odd parity).
module tb_uart_tx_fifo;

    localparam int DIV = 104;
    localparam int HALF = DIV / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       put = 1'b0, clr = 1'b0;
    logic [7:0] data = '0;
    logic       tx, busy, empty, full, ovf;
    logic [4:0] count;
    logic [2:0] st;

    logic       put7 = 1'b0;
    logic [6:0] data7 = '0;
    logic       tx_e, busy_e, empty_e, full_e, ovf_e;
    logic       tx_o, busy_o, empty_o, full_o, ovf_o;
    logic [4:0] count_e, count_o;
    logic [2:0] st_e, st_o;

    uart_tx_fifo dut (
        .clk(clk), .rst(rst), .put(put), .data(data), .clr_overflow(clr),
        .TX(tx), .tx_busy(busy), .empty(empty), .full(full), .count(count),
        .overflow(ovf), .fsm_state(st)
    );

    uart_tx_fifo #(.data_bits(7), .parity(2), .stop_bits(2)) dut_even (
        .clk(clk), .rst(rst), .put(put7), .data(data7), .clr_overflow(1'b0),
        .TX(tx_e), .tx_busy(busy_e), .empty(empty_e), .full(full_e), .count(count_e),
        .overflow(ovf_e), .fsm_state(st_e)
    );

    uart_tx_fifo #(.data_bits(7), .parity(1), .stop_bits(2)) dut_odd (
        .clk(clk), .rst(rst), .put(put7), .data(data7), .clr_overflow(1'b0),
        .TX(tx_o), .tx_busy(busy_o), .empty(empty_o), .full(full_o), .count(count_o),
        .overflow(ovf_o), .fsm_state(st_o)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the frame's start bit already on the line, offset cycles into it.
    // Returns after the frame's last stop cycle, i.e. at the next frame's first cycle.
    task automatic rx_byte(input int offset, output logic [7:0] b, output logic busy_end);
        repeat (HALF - offset) tick();
        check("start_bit", tx, 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat (DIV) tick();
            b[k] = tx;
        end
        repeat (DIV) tick();
        check("stop_bit", tx, 1'b1);
        repeat (HALF - 1) tick();
        busy_end = busy;
        tick();
    endtask

    logic [7:0]  b;
    logic        be;
    logic [10:0] exp_e, exp_o;
    int          low_cycles;

    initial begin
        // Test 1: reset state and a single 0x55 frame.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 5'd0);
        check("rst_ovf", ovf, 1'b0);

        put = 1'b1; data = 8'h55;
        tick();
        put = 1'b0;
        check("t1_empty_after_put", empty, 1'b0);
        check("t1_count_after_put", count, 5'd1);
        check("t1_tx_still_idle", tx, 1'b1);
        tick();
        check("t1_tx_fall", tx, 1'b0);
        check("t1_busy_rise", busy, 1'b1);
        check("t1_empty_after_pop", empty, 1'b1);
        rx_byte(0, b, be);
        check("t1_byte", b, 8'h55);
        check("t1_busy_last_cycle", be, 1'b1);
        check("t1_busy_end", busy, 1'b0);
        check("t1_tx_idle", tx, 1'b1);

        // Test 2: three back-to-back frames.
        put = 1'b1; data = 8'h41;
        tick();
        check("t2_count_a", count, 5'd1);
        data = 8'h42;
        tick();
        check("t2_count_b", count, 5'd1);
        check("t2_tx_start", tx, 1'b0);
        data = 8'h43;
        tick();
        put = 1'b0;
        check("t2_count_c", count, 5'd2);
        rx_byte(1, b, be);
        check("t2_byte0", b, 8'h41);
        check("t2_no_gap0", tx, 1'b0);
        check("t2_count_after0", count, 5'd1);
        rx_byte(0, b, be);
        check("t2_byte1", b, 8'h42);
        check("t2_no_gap1", tx, 1'b0);
        check("t2_busy1", busy, 1'b1);
        check("t2_count_after1", count, 5'd0);
        rx_byte(0, b, be);
        check("t2_byte2", b, 8'h43);
        check("t2_busy_last", be, 1'b1);
        check("t2_busy_end", busy, 1'b0);

        // Test 3 and 6: fill past depth, then overflow set-vs-clear priority.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            put = 1'b1;
            data = 8'(8'h10 + i - 1);
            tick();
            check("t3_count", count, (i == 1) ? 5'd1 : ((i - 1 > 16) ? 5'd16 : 5'(i - 1)));
            check("t3_full", full, (i >= 17) ? 1'b1 : 1'b0);
            check("t3_ovf", ovf, (i == 18) ? 1'b1 : 1'b0);
        end
        data = 8'h77; clr = 1'b1;
        tick();
        check("t6_set_wins", ovf, 1'b1);
        check("t6_count_kept", count, 5'd16);
        put = 1'b0;
        tick();
        clr = 1'b0;
        check("t6_cleared", ovf, 1'b0);
        for (int k = 0; k < 17; k++) begin
            rx_byte((k == 0) ? 18 : 0, b, be);
            check("t3_byte", b, 8'(8'h10 + k));
        end
        check("t3_busy_end", busy, 1'b0);
        check("t3_empty_end", empty, 1'b1);
        low_cycles = 0;
        repeat (300) begin
            tick();
            if (tx == 1'b0) low_cycles++;
        end
        check("t3_no_extra_frame", low_cycles, 0);

        // Test 4: 7 data bits, 2 stop bits, even and odd parity.
        exp_e = 11'b11_1_0000111_0;
        exp_o = 11'b11_0_0000111_0;
        put7 = 1'b1; data7 = 7'h07;
        tick();
        put7 = 1'b0;
        tick();
        check("t4_even_start", tx_e, 1'b0);
        check("t4_odd_start", tx_o, 1'b0);
        for (int k = 0; k < 11; k++) begin
            repeat ((k == 0) ? HALF : DIV) tick();
            check("t4_even_bit", tx_e, exp_e[k]);
            check("t4_odd_bit", tx_o, exp_o[k]);
        end
        repeat (HALF - 1) tick();
        check("t4_even_busy_last", busy_e, 1'b1);
        check("t4_odd_busy_last", busy_o, 1'b1);
        tick();
        check("t4_even_busy_end", busy_e, 1'b0);
        check("t4_odd_busy_end", busy_o, 1'b0);

        // Test 5: reset during the 4th data bit with 3 characters queued.
        for (int i = 0; i < 4; i++) begin
            put = 1'b1;
            data = 8'(8'hA0 + i);
            tick();
        end
        put = 1'b0;
        repeat (448) tick();
        check("t5_count_before", count, 5'd3);
        check("t5_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_tx", tx, 1'b1);
        check("t5_busy", busy, 1'b0);
        check("t5_empty", empty, 1'b1);
        check("t5_count", count, 5'd0);
        low_cycles = 0;
        repeat (1200) begin
            tick();
            if (tx == 1'b0 || busy == 1'b1) low_cycles++;
        end
        check("t5_no_frames", low_cycles, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
